host_cmd_master: RTL and testbench
==================================

HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-003 SHALL have parameter RSP_TIMEOUT, default 1023, response wait limit in CLK cycles.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_type  input  2  command type: 00 write, 01 read, 10 ALU with operands, 11 ALU without operands.
REQ-009 cmd_addr  input  ADDR_WIDTH  register address.
REQ-010 cmd_wdata, cmd_op_a, cmd_op_b  input  DATA_WIDTH each  write data, operand A, operand B.
REQ-011 cmd_fun  input  4  ALU function code.
REQ-012 TX_P_DATA  output  DATA_WIDTH  frame byte to UART transmitter.
REQ-013 TX_D_VLD  output  1  byte valid; byte transferred when TX_D_VLD and tx_ready are both high.
REQ-014 tx_ready  input  1  UART transmitter can take a byte.
REQ-015 RX_P_DATA  input  DATA_WIDTH  byte from UART receiver.
REQ-016 RX_D_VLD  input  1  one-cycle pulse, RX_P_DATA valid.
REQ-017 rsp_valid  output  1  one-cycle completion pulse.
REQ-018 rsp_data  output  2*DATA_WIDTH  response payload.
REQ-019 rsp_err  output  1  response timed out; qualified by rsp_valid.

Function
REQ-020 Frames transmitted, first byte first: write = AA, addr, wdata; read = BB, addr; ALU with operands = CC, op_a, op_b, fun; ALU without operands = DD, fun.
REQ-021 Address byte = cmd_addr zero-extended to DATA_WIDTH; function byte = cmd_fun zero-extended to DATA_WIDTH.
REQ-022 cmd_ready SHALL be high only in IDLE. All cmd_* fields SHALL be registered on acceptance and ignored afterwards.
REQ-023 States: IDLE, SEND, WAIT_RSP0, WAIT_RSP1, DONE.
REQ-024 IDLE -> SEND on acceptance. The first byte SHALL appear on TX_P_DATA with TX_D_VLD=1 on the next cycle.
REQ-025 In SEND, each accepted byte advances a byte index. The next byte SHALL be presented on the cycle after acceptance, so peak rate is one byte per cycle when tx_ready is held high.
REQ-026 TX_P_DATA and TX_D_VLD SHALL be registered outputs. TX_P_DATA SHALL hold stable while TX_D_VLD=1 and tx_ready=0. TX_D_VLD SHALL be 0 outside SEND.
REQ-027 After the last byte is accepted, the block SHALL move as follows: write -> DONE; read -> WAIT_RSP1 (one byte expected); ALU -> WAIT_RSP0 (two bytes expected).
REQ-028 WAIT_RSP0: on RX_D_VLD, capture rsp_data[7:0] and move to WAIT_RSP1.
REQ-029 WAIT_RSP1: on RX_D_VLD, capture rsp_data[15:8] for ALU commands or rsp_data[7:0] for read, then move to DONE. Read responses SHALL leave rsp_data[15:8]=0.
REQ-030 DONE: rsp_valid=1 for exactly one cycle, then IDLE. Write SHALL return rsp_data=0. rsp_data SHALL hold until the next command is accepted.
REQ-031 RX_D_VLD in IDLE, SEND or DONE SHALL be ignored, including a pulse in the same cycle as the last byte's acceptance.
REQ-032 Write completion latency: rsp_valid 2 cycles after the last byte is accepted.
REQ-033 rsp_data SHALL be cleared to 0 on command acceptance.

Reset
REQ-034 Asserting RST at any time, including mid-frame or mid-wait, SHALL abort the operation immediately with no rsp_valid.
REQ-035 Reset values: state IDLE; TX_D_VLD=0, TX_P_DATA=0, rsp_valid=0, rsp_data=0, rsp_err=0, byte index 0, timeout counter 0; cmd_ready=1.

Configuration
REQ-036 Macro HOST_CMD_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_RSP0/WAIT_RSP1 and on each RX_D_VLD, and increment each cycle in those states.
REQ-037 With HOST_CMD_TIMEOUT_EN defined, when the counter reaches RSP_TIMEOUT the block SHALL go to DONE and pulse rsp_valid with rsp_err=1, and rsp_data SHALL keep only the bytes already captured.
REQ-038 Macro undefined: no counter is built, WAIT states wait indefinitely, and rsp_err SHALL be constant 0.

Verification
REQ-039 Write, addr=5, wdata=3C, tx_ready=1 -> TX bytes AA,05,3C on consecutive cycles, then rsp_valid with rsp_data=0000, rsp_err=0.
REQ-040 Read, addr=2, then RX byte 7E -> TX bytes BB,02, then rsp_valid with rsp_data=007E.
REQ-041 ALU, op_a=0A, op_b=14, fun=0, then RX bytes 1E,00 -> TX bytes CC,0A,14,00, then rsp_valid with rsp_data=001E.
REQ-042 DD fun=2, tx_ready toggling 1/0 -> bytes DD,02 each held stable while stalled; cmd_ready=0 and a second cmd_valid is not accepted until IDLE.
REQ-043 HOST_CMD_TIMEOUT_EN, RSP_TIMEOUT=16, ALU command, one RX byte 55 then silence -> rsp_valid with rsp_err=1 and rsp_data=0055 sixteen cycles after the 55.
REQ-044 RST pulsed after the 2nd byte of a CC frame -> TX_D_VLD=0 and cmd_ready=1; the next command's frame starts cleanly with its first byte.

Source files
------------

// File: rtl/host_cmd_master.sv
// Host command master: turns write/read/ALU commands into UART byte frames and collects the reply bytes.
// Optional build macro HOST_CMD_TIMEOUT_EN adds a response watchdog that reports rsp_err.
module host_cmd_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int RSP_TIMEOUT = 1023
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH-1:0]   cmd_op_a,
    input  logic [DATA_WIDTH-1:0]   cmd_op_b,
    input  logic [3:0]              cmd_fun,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RSP0 = 3'd2,
        WAIT_RSP1 = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR      = 2'b00;
    localparam logic [1:0] CMD_RD      = 2'b01;
    localparam logic [1:0] CMD_ALU     = 2'b10;
    localparam logic [1:0] CMD_ALU_NOP = 2'b11;

    localparam logic [DATA_WIDTH-1:0] HDR_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU     = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU_NOP = DATA_WIDTH'(8'hDD);

    // Header bytes, address and function code must fit in one frame byte.
    if (DATA_WIDTH < 8 || ADDR_WIDTH > DATA_WIDTH || RSP_TIMEOUT < 2) begin : g_bad_param
        $error("host_cmd_master: unsupported parameter combination");
    end

    // Byte at position idx of the frame for command type ctype.
    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]            ctype,
        input logic [1:0]            idx,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] op_a,
        input logic [DATA_WIDTH-1:0] op_b,
        input logic [3:0]            fun
    );
        logic [DATA_WIDTH-1:0] addr_b;
        logic [DATA_WIDTH-1:0] fun_b;
        logic [DATA_WIDTH-1:0] byte_v;
        addr_b = DATA_WIDTH'(addr);
        fun_b  = DATA_WIDTH'(fun);
        case (ctype)
            CMD_WR: begin
                case (idx)
                    2'd0:    byte_v = HDR_WR;
                    2'd1:    byte_v = addr_b;
                    default: byte_v = wdata;
                endcase
            end
            CMD_RD: begin
                case (idx)
                    2'd0:    byte_v = HDR_RD;
                    default: byte_v = addr_b;
                endcase
            end
            CMD_ALU: begin
                case (idx)
                    2'd0:    byte_v = HDR_ALU;
                    2'd1:    byte_v = op_a;
                    2'd2:    byte_v = op_b;
                    default: byte_v = fun_b;
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    byte_v = HDR_ALU_NOP;
                    default: byte_v = fun_b;
                endcase
            end
        endcase
        return byte_v;
    endfunction

    // Index of the final byte in a frame of the given type.
    function automatic logic [1:0] last_idx(input logic [1:0] ctype);
        logic [1:0] li;
        case (ctype)
            CMD_WR:      li = 2'd2;
            CMD_RD:      li = 2'd1;
            CMD_ALU:     li = 2'd3;
            CMD_ALU_NOP: li = 2'd1;
            default:     li = 2'd1;
        endcase
        return li;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [1:0]              idx_r, idx_nxt_s;
    logic [1:0]              type_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, op_a_r, op_b_r;
    logic [3:0]              fun_r;
    logic                    tx_vld_r, tx_vld_nxt_s;
    logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_nxt_s;
    logic                    rsp_valid_r, rsp_valid_nxt_s;
    logic [2*DATA_WIDTH-1:0] rsp_data_r, rsp_data_nxt_s;
    logic                    rsp_err_r, rsp_err_nxt_s;
    logic                    cmd_load_s;
    logic                    timeout_s;

`ifdef HOST_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt_r, to_cnt_nxt_s;
    logic             in_wait_s;

    // Watchdog: restarts on every reply byte, counts idle cycles while waiting.
    always_comb begin
        in_wait_s    = (state_r == WAIT_RSP0) || (state_r == WAIT_RSP1);
        to_cnt_nxt_s = {CNT_W{1'b0}};
        timeout_s    = 1'b0;
        if (in_wait_s && !RX_D_VLD) begin
            to_cnt_nxt_s = to_cnt_r + CNT_W'(1);
            timeout_s    = (to_cnt_r == CNT_W'(RSP_TIMEOUT - 1));
        end else begin
            to_cnt_nxt_s = {CNT_W{1'b0}};
            timeout_s    = 1'b0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_nxt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        tx_vld_nxt_s    = tx_vld_r;
        tx_data_nxt_s   = tx_data_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        cmd_load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tx_vld_nxt_s = 1'b0;
                if (cmd_valid) begin
                    cmd_load_s     = 1'b1;
                    state_nxt_s    = SEND;
                    idx_nxt_s      = 2'd0;
                    tx_vld_nxt_s   = 1'b1;
                    tx_data_nxt_s  = frame_byte(cmd_type, 2'd0, cmd_addr, cmd_wdata,
                                                cmd_op_a, cmd_op_b, cmd_fun);
                    rsp_data_nxt_s = {(2*DATA_WIDTH){1'b0}};
                    rsp_err_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (tx_vld_r && tx_ready) begin
                    if (idx_r == last_idx(type_r)) begin
                        tx_vld_nxt_s = 1'b0;
                        idx_nxt_s    = 2'd0;
                        case (type_r)
                            CMD_WR:  state_nxt_s = DONE;
                            CMD_RD:  state_nxt_s = WAIT_RSP1;
                            default: state_nxt_s = WAIT_RSP0;
                        endcase
                    end else begin
                        idx_nxt_s     = idx_r + 2'd1;
                        tx_data_nxt_s = frame_byte(type_r, idx_r + 2'd1, addr_r, wdata_r,
                                                   op_a_r, op_b_r, fun_r);
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            WAIT_RSP0: begin
                if (RX_D_VLD) begin
                    rsp_data_nxt_s[DATA_WIDTH-1:0] = RX_P_DATA;
                    state_nxt_s                    = WAIT_RSP1;
                end else if (timeout_s) begin
                    rsp_err_nxt_s = 1'b1;
                    state_nxt_s   = DONE;
                end else begin
                    state_nxt_s = WAIT_RSP0;
                end
            end
            WAIT_RSP1: begin
                if (RX_D_VLD) begin
                    // ALU replies fill the high byte second; read replies have only a low byte.
                    if (type_r[1]) begin
                        rsp_data_nxt_s[2*DATA_WIDTH-1:DATA_WIDTH] = RX_P_DATA;
                    end else begin
                        rsp_data_nxt_s[DATA_WIDTH-1:0] = RX_P_DATA;
                    end
                    state_nxt_s = DONE;
                end else if (timeout_s) begin
                    rsp_err_nxt_s = 1'b1;
                    state_nxt_s   = DONE;
                end else begin
                    state_nxt_s = WAIT_RSP1;
                end
            end
            DONE: begin
                rsp_valid_nxt_s = 1'b1;
                state_nxt_s     = IDLE;
            end
            default: begin
                state_nxt_s  = IDLE;
                tx_vld_nxt_s = 1'b0;
                idx_nxt_s    = 2'd0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            tx_vld_r    <= 1'b0;
            tx_data_r   <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {(2*DATA_WIDTH){1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            tx_vld_r    <= tx_vld_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    // Command fields captured once on acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            type_r  <= 2'b00;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            op_a_r  <= {DATA_WIDTH{1'b0}};
            op_b_r  <= {DATA_WIDTH{1'b0}};
            fun_r   <= 4'h0;
        end else if (cmd_load_s) begin
            type_r  <= cmd_type;
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
            op_a_r  <= cmd_op_a;
            op_b_r  <= cmd_op_b;
            fun_r   <= cmd_fun;
        end
    end

    assign cmd_ready = (state_r == IDLE);
    assign TX_P_DATA = tx_data_r;
    assign TX_D_VLD  = tx_vld_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_host_cmd_master.sv
// Scoreboard bench for host_cmd_master: expected frames and replies are queued at issue time
// and a negedge monitor pops and compares them; HOST_CMD_TIMEOUT_EN adds a watchdog scenario.
module tb_host_cmd_master;

    localparam int DW = 8;
    localparam int AW = 4;
`ifdef HOST_CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1023;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, cmd_op_a, cmd_op_b;
    logic [3:0]    cmd_fun;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          tx_ready;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic          rsp_valid;
    logic [2*DW-1:0] rsp_data;
    logic          rsp_err;

    host_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
        .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .tx_ready(tx_ready),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  tx_q[$];
    rsp_t        rsp_q[$];
    bit          busy = 1'b0;
    int          tx_acc = 0;
    logic [15:0] last_rsp = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares every transferred byte and every response against the scoreboard.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_rsp;
        logic [7:0] eb;
        rsp_t       er;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_rsp   = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1) begin
                prev_stall = 1'b0;
                prev_rsp   = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_vld", TX_D_VLD, 1);
                    chk("tx_hold_data", TX_P_DATA, prev_data);
                end
                if (TX_D_VLD === 1'b1 && tx_ready === 1'b1) begin
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected_byte", {24'h0, TX_P_DATA}, 32'h1_0000);
                    end else begin
                        eb = tx_q.pop_front();
                        chk("tx_byte", TX_P_DATA, eb);
                    end
                    tx_acc++;
                end
                prev_stall = TX_D_VLD && !tx_ready;
                prev_data  = TX_P_DATA;
                if (busy && rsp_valid !== 1'b1) chk("cmd_ready_busy", cmd_ready, 0);
                if (rsp_valid === 1'b1) begin
                    chk("rsp_single_pulse", prev_rsp, 0);
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", {16'h0, rsp_data}, 32'h1_0000);
                    end else begin
                        er = rsp_q.pop_front();
                        chk("rsp_data", rsp_data, er.data);
                        chk("rsp_err", rsp_err, er.err);
                    end
                    busy = 1'b0;
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    task automatic randomize_cmd_pins();
        cmd_type  = 2'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = 8'($urandom);
        cmd_op_a  = 8'($urandom);
        cmd_op_b  = 8'($urandom);
        cmd_fun   = 4'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
    endtask

    // Issues one command; mode 0 random tx_ready, 1 always ready, 2 toggling with a held second request.
    task automatic run_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wd,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                           input int mode, input logic [7:0] r0, input logic [7:0] r1,
                           input int nrx);
        rsp_t er;
        int   nbytes, iters, lat, need;
        wait_idle();
        chk("rsp_data_hold", rsp_data, last_rsp);
        tx_q.delete();
        case (t)
            2'b00: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, addr}); tx_q.push_back(wd); end
            2'b01: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, addr}); end
            2'b10: begin tx_q.push_back(8'hCC); tx_q.push_back(a); tx_q.push_back(b);
                         tx_q.push_back({4'h0, fun}); end
            default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, fun}); end
        endcase
        nbytes = tx_q.size();
        need   = (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
        if (t == 2'b00)      er.data = 16'h0000;
        else if (t == 2'b01) er.data = {8'h00, r0};
        else if (nrx >= 2)   er.data = {r1, r0};
        else if (nrx == 1)   er.data = {8'h00, r0};
        else                 er.data = 16'h0000;
        er.err = (nrx < need);
        rsp_q.push_back(er);
        last_rsp = er.data;
        cmd_type = t; cmd_addr = addr; cmd_wdata = wd; cmd_op_a = a; cmd_op_b = b; cmd_fun = fun;
        cmd_valid = 1'b1;
        RX_D_VLD  = 1'b0;
        @(posedge CLK); #1;
        busy = 1'b1;
        cmd_valid = 1'b0;
        iters = 0;
        while (tx_q.size() != 0 && iters < 200) begin
            case (mode)
                0:       tx_ready = ($urandom_range(0, 3) != 0);
                1:       tx_ready = 1'b1;
                default: tx_ready = (iters % 2 == 1);
            endcase
            RX_D_VLD  = ($urandom_range(0, 3) == 0);
            RX_P_DATA = 8'($urandom);
            cmd_valid = (mode == 2) ? 1'b1 : 1'($urandom);
            randomize_cmd_pins();
            @(posedge CLK); #1;
            iters++;
        end
        chk("frame_complete", tx_q.size(), 0);
        RX_D_VLD  = 1'b0;
        cmd_valid = 1'b0;
        tx_ready  = 1'($urandom);
        if (mode == 1) chk("tx_one_byte_per_cycle", iters, nbytes);
        for (int k = 0; k < nrx && k < need; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
            RX_D_VLD  = 1'b1;
            RX_P_DATA = (k == 0) ? r0 : r1;
            @(posedge CLK); #1;
            RX_D_VLD  = 1'b0;
            RX_P_DATA = 8'($urandom);
        end
        lat = 0;
        while (rsp_q.size() != 0 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("rsp_arrived", rsp_q.size(), 0);
        if (t == 2'b00) chk("write_latency", lat, 2);
        if (er.err) chk("timeout_window", (lat >= TO) && (lat <= TO + 3), 1);
    endtask

    // Aborts a CC frame right after its second byte with an asynchronous reset.
    task automatic reset_mid_frame();
        int start, it;
        wait_idle();
        tx_q.delete();
        tx_q.push_back(8'hCC); tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h03);
        cmd_type = 2'b10; cmd_op_a = 8'h11; cmd_op_b = 8'h22; cmd_fun = 4'h3;
        cmd_valid = 1'b1;
        tx_ready  = 1'b1;
        start = tx_acc;
        @(posedge CLK); #1;
        busy = 1'b1;
        cmd_valid = 1'b0;
        it = 0;
        while (tx_acc < start + 2 && it < 50) begin
            @(posedge CLK); #1;
            it++;
        end
        chk("reset_two_bytes_sent", tx_acc - start, 2);
        RST = 1'b0;
        #1;
        chk("reset_tx_vld", TX_D_VLD, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        tx_q.delete();
        rsp_q.delete();
        busy = 1'b0;
        last_rsp = 16'h0000;
        @(posedge CLK); #1;
        chk("reset_held_tx_vld", TX_D_VLD, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] t;
        RST = 1'b0;
        cmd_valid = 1'b0;
        tx_ready  = 1'b0;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
        randomize_cmd_pins();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_tx_data", TX_P_DATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        RST = 1'b1;
        @(posedge CLK); #1;

        run_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1, 8'h00, 8'h00, 0);
        run_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h7E, 8'h00, 1);
        run_cmd(2'b10, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0, 1, 8'h1E, 8'h00, 2);
        run_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 2, 8'hA5, 8'h5A, 2);
        reset_mid_frame();
        run_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 1, 8'h01, 8'h80, 2);

        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom);
            run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                    0, 8'($urandom), 8'($urandom), (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2);
        end

`ifdef HOST_CMD_TIMEOUT_EN
        run_cmd(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3, 1, 8'h55, 8'h00, 1);
        run_cmd(2'b01, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h00, 8'h00, 0);
        run_cmd(2'b01, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 8'h42, 8'h00, 1);
`endif

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
